// File: rtl/parity_pkg.sv
// Shared constants and FSM state type for the serial parity frame checker.
package parity_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    // start + NIBBLE_W data + parity + stop
    localparam int unsigned FRAME_BITS = 7;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Receive-side bus of the frame checker: serial line in, deframed nibble and status out.
interface parity_frame_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             bit_valid;
    logic             serial_in;
    logic             clear_cnt;
    logic [3:0]       data_out;
    logic             data_valid;
    logic             parity_err;
    logic             frame_err;
    logic [CNT_W-1:0] err_count;
    logic             busy;

    // Upstream driver / status reader
    modport master (
        output bit_valid, serial_in, clear_cnt,
        input  data_out, data_valid, parity_err, frame_err, err_count, busy
    );

    // The checker itself
    modport slave (
        input  bit_valid, serial_in, clear_cnt,
        output data_out, data_valid, parity_err, frame_err, err_count, busy
    );
endinterface

// File: rtl/parity_generator.sv
// Combinational even/odd parity of a data word.
module parity_generator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    output logic             even_parity,
    output logic             odd_parity
);
    // Reduction XOR and its complement
    assign even_parity = ^data;
    assign odd_parity  = ~^data;
endmodule

// File: rtl/parity_frame_checker.sv
// Deframes start/4 data/parity/stop serial frames, checks parity and stop bit,
// and keeps a saturating error count.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_frame_checker_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NIBBLE_W);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NIBBLE_W-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic [NIBBLE_W-1:0] data_q, data_d;
    logic                dv_q, dv_d;
    logic                pe_q, pe_d;
    logic                fe_q, fe_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                inc;
    logic                even_par, odd_par, exp_par;

    parity_generator #(
        .WIDTH (NIBBLE_W)
    ) u_parity_generator (
        .data        (shift_q),
        .even_parity (even_par),
        .odd_parity  (odd_par)
    );

    assign exp_par = ODD_PARITY ? odd_par : even_par;

    // Next-state, deframing and error-count update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        inc     = 1'b0;

        if (bus.bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[idx_q] = bus.serial_in;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NIBBLE_W - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = bus.serial_in;
                    state_d = STOP;
                end
                STOP: begin
                    // No wait for idle-high: the next 0 sampled is a start bit
                    state_d = IDLE;
                    if (bus.serial_in) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                        pe_d   = (par_q != exp_par);
                        inc    = pe_d;
                    end else begin
                        fe_d = 1'b1;
                        inc  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);

        // Clear beats a simultaneous increment; count sticks at all-ones
        cnt_d = cnt_q;
        if (bus.clear_cnt) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.err_count  = cnt_q;
    assign bus.busy       = busy_q;

endmodule
